// File: rtl/lut_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered lookup memory among NREQ
// requesters: accept -> issue read -> capture byte -> one-cycle response pulse.
module lut_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]        rsp_data_o,
    output logic                 mem_en_o,
    output logic [AW-1:0]        mem_addr_o,
    input  logic [DW-1:0]        mem_rdata_i,
    output logic                 busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     last_q, last_d;
    logic [PW-1:0]     win_q, win_d;
    logic              mem_en_q, mem_en_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;

    logic [AW-1:0]     addr_arr [NREQ];
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     idx_p;
    logic              found;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr_i[gi*AW +: AW];
    end

    // Search starts one past the last winner and wraps, so the most recent
    // winner has the lowest priority in the next arbitration.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        idx_p   = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_p = PW'((int'(last_q) + k) % NREQ);
            if (!found && req_valid_i[idx_p]) begin
                found        = 1'b1;
                grant[idx_p] = 1'b1;
                win_idx      = idx_p;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d      = win_idx;
                    last_d     = win_idx;
                    mem_en_d   = 1'b1;
                    mem_addr_d = addr_arr[win_idx];
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                rsp_data_d         = mem_rdata_i;
                rsp_valid_d[win_q] = 1'b1;
                state_d            = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_q      <= PW'(NREQ - 1);
            win_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_o = (state_q == IDLE) ? grant : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign mem_en_o    = mem_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Directed bench for lut_rr_arbiter with a registered, en-qualified lookup
// memory model (0->00, 1->01, F->0F, others->FF, reset value 80).
module tb_lut_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                mem_en;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_rdata;
    logic                busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lut_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .mem_en_o    (mem_en),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    function automatic logic [DW-1:0] lut(input logic [AW-1:0] a);
        case (a)
            4'h0:    return 8'h00;
            4'h1:    return 8'h01;
            4'hF:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mem_rdata <= 8'h80;
        else if (mem_en) mem_rdata <= lut(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    logic [DW-1:0]   exp_data2 [NREQ];
    logic [NREQ-1:0] exp_g;

    initial begin
        // ---- Test 1: reset values, single request, latency ----
        @(negedge clk);
        do_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h0);
        chk("rst_mem_en",    32'(mem_en),    32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_ready",     32'(req_ready), 32'h0);
        set_addr(0, 4'h1);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("t1_iss_en",   32'(mem_en),    32'h1);
        chk("t1_iss_addr", 32'(mem_addr),  32'h1);
        chk("t1_iss_busy", 32'(busy),      32'h1);
        chk("t1_iss_rdy",  32'(req_ready), 32'h0);
        tick();
        chk("t1_capt_en",   32'(mem_en),    32'h0);
        chk("t1_capt_addr", 32'(mem_addr),  32'h1);
        chk("t1_capt_busy", 32'(busy),      32'h1);
        chk("t1_capt_rv",   32'(rsp_valid), 32'h0);
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data",  32'(rsp_data),  32'h01);
        chk("t1_rsp_busy",  32'(busy),      32'h1);
        tick();
        chk("t1_idle_rv",   32'(rsp_valid), 32'h0);
        chk("t1_idle_busy", 32'(busy),      32'h0);
        chk("t1_hold_data", 32'(rsp_data),  32'h01);

        // ---- Test 2: all four valid, grants 0,1,2,3 every 4 cycles ----
        do_reset();
        exp_data2[0] = 8'h00; exp_data2[1] = 8'h01;
        exp_data2[2] = 8'h0F; exp_data2[3] = 8'hFF;
        set_addr(0, 4'h0); set_addr(1, 4'h1); set_addr(2, 4'hF); set_addr(3, 4'h5);
        req_valid = 4'b1111;
        for (int g = 0; g < NREQ; g++) begin
            #1;
            exp_g = NREQ'(1) << g;
            chk("t2_ready", 32'(req_ready), 32'(exp_g));
            tick();
            req_valid[g] = 1'b0;
            tick();
            tick();
            chk("t2_rsp_valid", 32'(rsp_valid), 32'(exp_g));
            chk("t2_rsp_data",  32'(rsp_data),  32'(exp_data2[g]));
            tick();
        end

        // ---- Test 3: req1 and req3 continuously valid alternate ----
        set_addr(1, 4'h2); set_addr(3, 4'h0);
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            chk("t3_ready", 32'(req_ready), 32'(exp_g));
            tick();
            chk("t3_mem_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h2 : 32'h0);
            tick();
            tick();
            chk("t3_rsp_valid", 32'(rsp_valid), 32'(exp_g));
            chk("t3_rsp_data",  32'(rsp_data),  (i % 2 == 0) ? 32'hFF : 32'h00);
            tick();
        end
        req_valid = '0;

        // ---- Test 4: reset during CAPT abandons the transaction ----
        set_addr(2, 4'h5);
        req_valid = 4'b0100;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk("t4_capt_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy",   32'(busy),      32'h0);
        chk("t4_rst_mem_en", 32'(mem_en),    32'h0);
        chk("t4_rst_data",   32'(rsp_data),  32'h0);
        tick();
        chk("t4_no_rsp", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t4_no_rsp2", 32'(rsp_valid), 32'h0);
        set_addr(2, 4'hF); set_addr(3, 4'h5);
        req_valid = 4'b1100;
        #1;
        chk("t4_ptr_restart", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t4_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t4_rsp_data",  32'(rsp_data),  32'h0F);
        tick();

        // ---- Test 5: addr change after accept; late requester ----
        set_addr(0, 4'h1);
        req_valid = 4'b0001;
        #1;
        chk("t5_ready0", 32'(req_ready), 32'h1);
        tick();
        set_addr(0, 4'hF);
        req_valid = 4'b0000;
        tick();
        set_addr(2, 4'h0);
        req_valid = 4'b0100;
        #1;
        chk("t5_capt_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t5_rsp_data",  32'(rsp_data),  32'h01);
        chk("t5_rsp_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t5_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t5_rsp2_valid", 32'(rsp_valid), 32'h4);
        chk("t5_rsp2_data",  32'(rsp_data),  32'h00);
        tick();
        chk("t5_final_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
